// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the memory queue scheduler.
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        TURN     = 2'd3
    } sched_state_t;

    // Direction encoding doubles as the mem_cmd_we value.
    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    // Memory word address is {queue_id, offset}; the caller truncates to its width.
    function automatic logic [31:0] pack_cmd_addr(input logic [31:0] qid,
                                                  input logic [31:0] offset,
                                                  input int          offset_w);
        return (qid << offset_w) | offset;
    endfunction

endpackage

// File: rtl/mem_queue_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after the pointer, wrapping.
import mem_sched_pkg::*;

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_cand;

    // Scan candidates in priority order starting at the pointer; keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!o_any && i_elig[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_queue_scheduler.sv
// Sequences one memory command port between NUM_QUEUES ring-buffer queues:
// round-robin write bursts, round-robin read bursts, turnaround gap between them.
import mem_sched_pkg::*;

module mem_queue_scheduler #(
    parameter int NUM_QUEUES     = 4,
    parameter int QUEUE_ID_WIDTH = 2,
    parameter int MEM_ADDR_WIDTH = 18,
    parameter int MAX_BURST      = 8,
    parameter int TURN_CYCLES    = 2
) (
    input  logic                      memclk,
    input  logic                      memreset,
    input  logic                      cal_done,
    input  logic [NUM_QUEUES-1:0]     wr_req,
    output logic [NUM_QUEUES-1:0]     wr_grant,
    input  logic [NUM_QUEUES-1:0]     rd_req,
    output logic [NUM_QUEUES-1:0]     rd_grant,
    output logic [NUM_QUEUES-1:0]     rd_credit,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [NUM_QUEUES-1:0]     q_empty,
    output logic [NUM_QUEUES-1:0]     q_full
);

    localparam int QAW         = MEM_ADDR_WIDTH - QUEUE_ID_WIDTH;
    localparam int QUEUE_WORDS = 2 ** QAW;
    localparam int BURST_W     = $clog2(MAX_BURST + 1);
    localparam int TURN_W      = $clog2(TURN_CYCLES + 1);

    sched_state_t              r_state, w_next_state;
    logic [BURST_W-1:0]        r_burst_cnt;
    logic [TURN_W-1:0]         r_turn_cnt;
    logic                      r_turn_dir;
    logic [QUEUE_ID_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [QAW-1:0]            r_tail  [NUM_QUEUES];
    logic [QAW-1:0]            r_head  [NUM_QUEUES];
    logic [QAW:0]              r_count [NUM_QUEUES];
    logic                      r_cmd_valid, r_cmd_we;
    logic [MEM_ADDR_WIDTH-1:0] r_cmd_addr;
    logic [NUM_QUEUES-1:0]     r_rd_credit;

    logic [NUM_QUEUES-1:0]     w_wr_elig, w_rd_elig, w_wr_oh, w_rd_oh;
    logic [QUEUE_ID_WIDTH-1:0] w_wr_idx, w_rd_idx;
    logic                      w_wr_any, w_rd_any;
    logic                      w_slot_free, w_last_beat, w_turn_done;
    logic                      w_wr_issue, w_rd_issue;
    logic [MEM_ADDR_WIDTH-1:0] w_cmd_addr;

    // Occupancy flags decoded from the per-queue counts.
    always_comb begin
        q_empty = '0;
        q_full  = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            q_empty[q] = (r_count[q] == '0);
            q_full[q]  = (r_count[q] == (QAW + 1)'(QUEUE_WORDS));
        end
    end

    assign w_wr_elig   = wr_req & ~q_full;
    assign w_rd_elig   = rd_req & ~q_empty;
    assign w_slot_free = !r_cmd_valid || mem_cmd_ready;
    assign w_last_beat = (r_burst_cnt == BURST_W'(MAX_BURST - 1));
    assign w_turn_done = (r_turn_cnt == TURN_W'(TURN_CYCLES - 1));

    rr_arbiter #(.N(NUM_QUEUES), .IW(QUEUE_ID_WIDTH)) u_wr_arb (
        .i_elig (w_wr_elig),
        .i_ptr  (r_wr_ptr),
        .o_grant(w_wr_oh),
        .o_idx  (w_wr_idx),
        .o_any  (w_wr_any)
    );

    rr_arbiter #(.N(NUM_QUEUES), .IW(QUEUE_ID_WIDTH)) u_rd_arb (
        .i_elig (w_rd_elig),
        .i_ptr  (r_rd_ptr),
        .o_grant(w_rd_oh),
        .o_idx  (w_rd_idx),
        .o_any  (w_rd_any)
    );

    // FSM state register.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next state: the final beat of a burst decides whether to turn or keep going.
    always_comb begin
        w_next_state = r_state;
        if (!cal_done) begin
            if (w_slot_free) w_next_state = IDLE;
        end else begin
            unique case (r_state)
                IDLE:     w_next_state = WR_BURST;
                WR_BURST: if ((w_wr_issue && w_last_beat && w_rd_any) || (!w_wr_any && w_rd_any))
                              w_next_state = TURN;
                RD_BURST: if ((w_rd_issue && w_last_beat && w_wr_any) || (!w_rd_any && w_wr_any))
                              w_next_state = TURN;
                TURN:     if (w_turn_done)
                              w_next_state = (r_turn_dir == DIR_RD) ? RD_BURST : WR_BURST;
                default:  w_next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: issue decision and the combinational grant pulses.
    always_comb begin
        w_wr_issue = (r_state == WR_BURST) && cal_done && w_slot_free && w_wr_any;
        w_rd_issue = (r_state == RD_BURST) && cal_done && w_slot_free && w_rd_any;
        wr_grant   = w_wr_issue ? w_wr_oh : '0;
        rd_grant   = w_rd_issue ? w_rd_oh : '0;
    end

    // Burst and turnaround counters; both restart on every state change.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) begin
            r_burst_cnt <= '0;
            r_turn_cnt  <= '0;
            r_turn_dir  <= DIR_WR;
        end else if (r_state != w_next_state) begin
            r_burst_cnt <= '0;
            r_turn_cnt  <= '0;
            if (w_next_state == TURN)
                r_turn_dir <= (r_state == WR_BURST) ? DIR_RD : DIR_WR;
        end else if (w_wr_issue || w_rd_issue) begin
            r_burst_cnt <= w_last_beat ? '0 : r_burst_cnt + BURST_W'(1);
        end else if (r_state == TURN) begin
            r_turn_cnt <= r_turn_cnt + TURN_W'(1);
        end
    end

    always_comb begin
        if (w_wr_issue)
            w_cmd_addr = MEM_ADDR_WIDTH'(pack_cmd_addr(32'(w_wr_idx), 32'(r_tail[w_wr_idx]), QAW));
        else
            w_cmd_addr = MEM_ADDR_WIDTH'(pack_cmd_addr(32'(w_rd_idx), 32'(r_head[w_rd_idx]), QAW));
    end

    // Command register: loads on issue, holds until accepted, drops when idle.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
        end else if (w_slot_free) begin
            r_cmd_valid <= w_wr_issue || w_rd_issue;
            if (w_wr_issue || w_rd_issue) begin
                r_cmd_we   <= w_wr_issue ? DIR_WR : DIR_RD;
                r_cmd_addr <= w_cmd_addr;
            end
        end
    end

    // Ring pointers, occupancy and RR pointers move at the same edge as the command load.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                r_tail[q]  <= '0;
                r_head[q]  <= '0;
                r_count[q] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_wr_issue) begin
            r_tail[w_wr_idx]  <= r_tail[w_wr_idx] + QAW'(1);
            r_count[w_wr_idx] <= r_count[w_wr_idx] + (QAW + 1)'(1);
            r_wr_ptr          <= w_wr_idx + QUEUE_ID_WIDTH'(1);
        end else if (w_rd_issue) begin
            r_head[w_rd_idx]  <= r_head[w_rd_idx] + QAW'(1);
            r_count[w_rd_idx] <= r_count[w_rd_idx] - (QAW + 1)'(1);
            r_rd_ptr          <= w_rd_idx + QUEUE_ID_WIDTH'(1);
        end
    end

    // Credit is the read grant delayed by one cycle.
    always_ff @(posedge memclk or posedge memreset) begin
        if (memreset) r_rd_credit <= '0;
        else          r_rd_credit <= rd_grant;
    end

    assign mem_cmd_valid = r_cmd_valid;
    assign mem_cmd_we    = r_cmd_we;
    assign mem_cmd_addr  = r_cmd_addr;
    assign rd_credit     = r_rd_credit;

endmodule

// File: tb/tb_mem_queue_scheduler.sv
// Bench for mem_queue_scheduler with 16-word queues (MEM_ADDR_WIDTH = 6).
module tb_mem_queue_scheduler;

    localparam int NQ = 4;
    localparam int QW = 16;

    logic       memclk = 1'b0;
    logic       memreset, cal_done, mem_cmd_ready;
    logic [3:0] wr_req, rd_req;
    logic [3:0] wr_grant, rd_grant, rd_credit, q_empty, q_full;
    logic       mem_cmd_valid, mem_cmd_we;
    logic [5:0] mem_cmd_addr;

    mem_queue_scheduler #(
        .NUM_QUEUES(4), .QUEUE_ID_WIDTH(2), .MEM_ADDR_WIDTH(6),
        .MAX_BURST(8), .TURN_CYCLES(2)
    ) dut (
        .memclk       (memclk),
        .memreset     (memreset),
        .cal_done     (cal_done),
        .wr_req       (wr_req),
        .wr_grant     (wr_grant),
        .rd_req       (rd_req),
        .rd_grant     (rd_grant),
        .rd_credit    (rd_credit),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we   (mem_cmd_we),
        .mem_cmd_addr (mem_cmd_addr),
        .q_empty      (q_empty),
        .q_full       (q_full)
    );

    always #5 memclk = ~memclk;

    // Reference model: occupancy and ring offsets per queue, RR pointers, expected command.
    int         occ [NQ];
    int         head_m [NQ];
    int         tail_m [NQ];
    int         wr_rr, rd_rr;
    logic       exp_valid, exp_we;
    logic [5:0] exp_addr;
    logic [3:0] prev_rd, last_wr, last_rd, last_credit;
    int         n_checks, n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            occ[q] = 0; head_m[q] = 0; tail_m[q] = 0;
        end
        wr_rr = 0; rd_rr = 0;
        exp_valid = 1'b0; exp_we = 1'b0; exp_addr = '0;
        prev_rd = '0;
    endtask

    function automatic logic [3:0] m_full();
        logic [3:0] f = '0;
        for (int q = 0; q < NQ; q++) f[q] = (occ[q] == QW);
        return f;
    endfunction

    function automatic logic [3:0] m_empty();
        logic [3:0] e = '0;
        for (int q = 0; q < NQ; q++) e[q] = (occ[q] == 0);
        return e;
    endfunction

    function automatic int rr_pick(input logic [3:0] elig, input int ptr);
        for (int k = 0; k < NQ; k++)
            if (elig[(ptr + k) % NQ]) return (ptr + k) % NQ;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int q);
        return (q < 0) ? 4'b0000 : 4'(1 << q);
    endfunction

    // One clock: inputs were set at the falling edge; sample 2 ns later, check, advance model.
    task automatic step();
        int wq, rq;
        logic busy;
        #2;
        chk("cmd_valid", 32'(mem_cmd_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("cmd_we", 32'(mem_cmd_we), 32'(exp_we));
            chk("cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr));
        end
        chk("rd_credit", 32'(rd_credit), 32'(prev_rd));
        chk("q_empty", 32'(q_empty), 32'(m_empty()));
        chk("q_full", 32'(q_full), 32'(m_full()));
        chk("dual_grant", 32'((wr_grant != 0) && (rd_grant != 0)), 32'(0));
        last_wr = wr_grant; last_rd = rd_grant; last_credit = rd_credit;
        busy = exp_valid && !mem_cmd_ready;
        if (wr_grant != 0) begin
            wq = rr_pick(wr_req & ~m_full(), wr_rr);
            chk("wr_pick", 32'(wr_grant), 32'(onehot(wq)));
            chk("wr_slot_busy", 32'(busy), 32'(0));
            chk("wr_cal", 32'(cal_done), 32'(1));
            if (wq >= 0) begin
                exp_addr = 6'((wq << 4) | tail_m[wq]);
                exp_we = 1'b1; exp_valid = 1'b1;
                tail_m[wq] = (tail_m[wq] + 1) % QW;
                occ[wq]++;
                wr_rr = (wq + 1) % NQ;
            end
        end else if (rd_grant != 0) begin
            rq = rr_pick(rd_req & ~m_empty(), rd_rr);
            chk("rd_pick", 32'(rd_grant), 32'(onehot(rq)));
            chk("rd_slot_busy", 32'(busy), 32'(0));
            chk("rd_cal", 32'(cal_done), 32'(1));
            if (rq >= 0) begin
                exp_addr = 6'((rq << 4) | head_m[rq]);
                exp_we = 1'b0; exp_valid = 1'b1;
                head_m[rq] = (head_m[rq] + 1) % QW;
                occ[rq]--;
                rd_rr = (rq + 1) % NQ;
            end
        end else if (!busy) begin
            exp_valid = 1'b0;
        end
        prev_rd = rd_grant;
        @(negedge memclk);
    endtask

    task automatic do_reset();
        memreset = 1'b1;
        model_reset();
        @(negedge memclk);
        @(negedge memclk);
        memreset = 1'b0;
        chk("rst_release_empty", 32'(q_empty), 32'(4'hF));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, nrd, ncred, pick;
        n_checks = 0; n_pass = 0;
        memreset = 1'b1; cal_done = 1'b0; wr_req = '0; rd_req = '0; mem_cmd_ready = 1'b1;
        model_reset();

        // Reset values.
        @(negedge memclk); #2;
        chk("rst_valid", 32'(mem_cmd_valid), 32'(0));
        chk("rst_we", 32'(mem_cmd_we), 32'(0));
        chk("rst_addr", 32'(mem_cmd_addr), 32'(0));
        chk("rst_empty", 32'(q_empty), 32'(4'hF));
        chk("rst_full", 32'(q_full), 32'(0));
        chk("rst_grant", 32'({wr_grant, rd_grant}), 32'(0));
        chk("rst_credit", 32'(rd_credit), 32'(0));

        // Calibration pending: requests present but nothing issues.
        @(negedge memclk);
        memreset = 1'b0; wr_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nocal_grant", 32'({last_wr, last_rd}), 32'(0));
        end

        // Fill every queue round-robin until all are full.
        cal_done = 1'b1; n = 0; cyc = 0;
        while (n < 64 && cyc < 200) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("fill_cnt", 32'(n), 32'(64));
        chk("fill_full", 32'(q_full), 32'(4'hF));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_nogrant", 32'(last_wr), 32'(0));
        end

        // Start draining, then reset asynchronously in the middle of the read burst.
        wr_req = '0; rd_req = 4'hF; n = 0; cyc = 0;
        while (n < 5 && cyc < 40) begin
            step();
            if (last_rd != 0) n++;
            cyc++;
        end
        chk("drain_cnt", 32'(n), 32'(5));
        #2;
        chk("pre_rst_rd", 32'(rd_grant != 0), 32'(1));
        #1 memreset = 1'b1;
        #1;
        chk("midrst_valid", 32'(mem_cmd_valid), 32'(0));
        chk("midrst_grant", 32'({wr_grant, rd_grant}), 32'(0));
        model_reset();
        @(negedge memclk);
        @(negedge memclk);
        memreset = 1'b0; rd_req = '0;
        chk("midrst_empty", 32'(q_empty), 32'(4'hF));
        step();

        // Turnaround: 8 words into q1, then writes on q0/q2 compete with reads on q1.
        wr_req = 4'b0010; n = 0; cyc = 0;
        while (n < 8 && cyc < 40) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("q1_fill", 32'(n), 32'(8));
        wr_req = 4'b0101; rd_req = 4'b0010;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i < 8)       chk("turn_wr", 32'(last_wr != 0), 32'(1));
            else if (i < 10) chk("turn_gap", 32'({last_wr, last_rd}), 32'(0));
            else             chk("turn_rd", 32'(last_rd), 32'(4'b0010));
        end

        // Backpressure: command must hold and no grant may fire while ready is low.
        rd_req = '0; wr_req = 4'b0001; n = 0; cyc = 0;
        while (n < 1 && cyc < 20) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("stall_pre", 32'(n), 32'(1));
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_grant", 32'({last_wr, last_rd}), 32'(0));
            chk("stall_valid", 32'(mem_cmd_valid), 32'(1));
        end
        mem_cmd_ready = 1'b1;
        step();
        chk("stall_resume", 32'(last_wr), 32'(4'b0001));

        // Queue 2: fill 16, drain 16 with credits, then check the offset wraps to 0.
        do_reset();
        wr_req = 4'b0100; rd_req = '0; n = 0; cyc = 0;
        while (n < 16 && cyc < 60) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("q2_fill_cnt", 32'(n), 32'(16));
        chk("q2_full", 32'(q_full[2]), 32'(1));
        wr_req = '0; rd_req = 4'b0100; nrd = 0; ncred = 0; cyc = 0;
        while (nrd < 16 && cyc < 80) begin
            step();
            if (last_credit[2]) ncred++;
            if (last_rd != 0) begin
                chk("q2_rd_addr", 32'(mem_cmd_addr), 32'(32 + nrd));
                nrd++;
            end
            cyc++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            if (last_credit[2]) ncred++;
        end
        chk("q2_rd_cnt", 32'(nrd), 32'(16));
        chk("q2_credits", 32'(ncred), 32'(16));
        chk("q2_empty", 32'(q_empty[2]), 32'(1));
        rd_req = '0; wr_req = 4'b0100; n = 0; cyc = 0;
        while (n < 1 && cyc < 20) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("q2_wrap", 32'(mem_cmd_addr), 32'(6'h20));

        // Calibration lost mid-burst, then regained: RR pointer must be preserved.
        wr_req = 4'hF; n = 0; cyc = 0;
        while (n < 3 && cyc < 20) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        cal_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("caloff_grant", 32'({last_wr, last_rd}), 32'(0));
        end
        chk("caloff_valid", 32'(mem_cmd_valid), 32'(0));
        pick = wr_rr;
        cal_done = 1'b1; n = 0; cyc = 0;
        while (n < 1 && cyc < 10) begin
            step();
            if (last_wr != 0) n++;
            cyc++;
        end
        chk("cal_resume", 32'(last_wr), 32'(onehot(pick)));
        chk("cal_resume_lat", 32'(cyc), 32'(2));

        // Randomized traffic against the model.
        do_reset();
        n = 0;
        for (int i = 0; i < 1500; i++) begin
            wr_req = 4'($urandom);
            rd_req = 4'($urandom);
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
            cal_done = ($urandom_range(0, 39) != 0);
            step();
            if (last_wr != 0 || last_rd != 0) n++;
        end
        chk("rand_activity", 32'(n > 100), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
